// File: rtl/seg_scan_decoder_if.sv
// Display-pin bus for the seven-segment readback: scanned pins in, decoded frame out.
// The decoder takes the slave side; the meter or bench driving the pins takes the master side.
interface seg_scan_decoder_if;
  logic [6:0]  led_seg;
  logic        a1, a2, a3, a4;
  logic [13:0] value;
  logic [3:0]  digit1, digit2, digit3, digit4;
  logic        frame_valid;
  logic        value_changed;
  logic        blanked;
  logic        seg_err;
  logic [7:0]  err_count;

  modport master (
    output led_seg, a1, a2, a3, a4,
    input  value, digit1, digit2, digit3, digit4, frame_valid, value_changed,
           blanked, seg_err, err_count
  );

  modport slave (
    input  led_seg, a1, a2, a3, a4,
    output value, digit1, digit2, digit3, digit4, frame_valid, value_changed,
           blanked, seg_err, err_count
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Reads back a multiplexed 4-digit seven-segment display: slot classify, BCD decode,
// frame capture, two-stage BCD->binary conversion, blank-run tracking and error counting.
module seg_scan_decoder #(
  parameter int BLANK_MIN = 8
) (
  input logic               clk,
  input logic               rst,
  seg_scan_decoder_if.slave bus
);
  localparam int         STAGES  = 2;
  localparam logic [7:0] RUN_MAX = 8'(BLANK_MIN);

  typedef enum logic [1:0] {HUNT = 2'd0, CAP2 = 2'd1, CAP3 = 2'd2, CAP4 = 2'd3} state_t;

  state_t          state, state_nx;
  logic [6:0]      s_seg;
  logic [3:0]      s_an_n;
  logic [3:0]      lit;
  logic            is_blank, pat_ok, good;
  logic [1:0]      slot;
  logic [3:0]      pat_d;
  logic            ld, publish, err_nx;
  logic [2:0][3:0] cap_d;
  logic [3:0][3:0] hand_d, a_d, dig;
  logic [13:0]     p_hi, p_lo, sum, value;
  logic [STAGES:0] vld_pipe;
  logic            first, value_changed, blanked, seg_err;
  logic [7:0]      run_cnt, err_count;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return {1'b1, 4'd0};
      7'b1001111: return {1'b1, 4'd1};
      7'b0010010: return {1'b1, 4'd2};
      7'b0000110: return {1'b1, 4'd3};
      7'b1001100: return {1'b1, 4'd4};
      7'b0100100: return {1'b1, 4'd5};
      7'b0100000: return {1'b1, 4'd6};
      7'b0001111: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0000100: return {1'b1, 4'd9};
      default:    return 5'd0;
    endcase
  endfunction

  // Sample classification on the registered pins; slot 0 = a1 (thousands).
  always_comb begin
    lit      = ~s_an_n;
    is_blank = (lit == 4'b0000);
    slot     = 2'd0;
    for (int i = 0; i < 4; i++)
      if (lit[i]) slot = 2'(i);
    {pat_ok, pat_d} = seg_decode(s_seg);
    good = $onehot(lit) && pat_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  // State encoding doubles as the slot index expected next.
  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    publish  = 1'b0;
    err_nx   = 1'b0;
    if (good && slot == 2'(state)) begin
      ld      = 1'b1;
      publish = (state == CAP4);
      case (state)
        HUNT:    state_nx = CAP2;
        CAP2:    state_nx = CAP3;
        CAP3:    state_nx = CAP4;
        default: state_nx = HUNT;
      endcase
    end else if (state != HUNT) begin
      err_nx = !is_blank;
      if (good && slot == 2'd0) begin
        ld       = 1'b1;
        state_nx = CAP2;
      end else begin
        state_nx = HUNT;
      end
    end
  end

  // Data path: frame digits and conversion stages carry no reset; vld_pipe gates them.
  always_ff @(posedge clk) begin
    if (ld) begin
      case (slot)
        2'd0:    cap_d[0] <= pat_d;
        2'd1:    cap_d[1] <= pat_d;
        2'd2:    cap_d[2] <= pat_d;
        default: ;
      endcase
    end
    if (publish) hand_d <= {pat_d, cap_d};
    if (vld_pipe[0]) begin
      p_hi <= 14'(hand_d[0]) * 14'd1000 + 14'(hand_d[1]) * 14'd100;
      p_lo <= 14'(hand_d[2]) * 14'd10 + 14'(hand_d[3]);
      a_d  <= hand_d;
    end
  end

  assign sum = p_hi + p_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg         <= '1;
      s_an_n        <= '1;
      vld_pipe      <= '0;
      first         <= 1'b1;
      run_cnt       <= '0;
      value         <= '0;
      dig           <= '0;
      value_changed <= 1'b0;
      blanked       <= 1'b0;
      seg_err       <= 1'b0;
      err_count     <= '0;
    end else begin
      s_seg    <= bus.led_seg;
      s_an_n   <= {bus.a4, bus.a3, bus.a2, bus.a1};
      vld_pipe <= {vld_pipe[STAGES-1:0], publish};
      seg_err  <= err_nx;
      if (err_nx && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (!is_blank)               run_cnt <= '0;
      else if (run_cnt < RUN_MAX)  run_cnt <= run_cnt + 8'd1;
      // A new blank run reaching the threshold wins over a same-edge publish.
      if (is_blank && run_cnt >= RUN_MAX - 8'd1) blanked <= 1'b1;
      else if (vld_pipe[STAGES-1])               blanked <= 1'b0;
      if (vld_pipe[STAGES-1]) begin
        value         <= sum;
        dig           <= a_d;
        value_changed <= first || (sum != value);
        first         <= 1'b0;
      end else begin
        value_changed <= 1'b0;
      end
    end
  end

  assign bus.value         = value;
  assign bus.digit1        = dig[0];
  assign bus.digit2        = dig[1];
  assign bus.digit3        = dig[2];
  assign bus.digit4        = dig[3];
  assign bus.frame_valid   = vld_pipe[STAGES];
  assign bus.value_changed = value_changed;
  assign bus.blanked       = blanked;
  assign bus.seg_err       = seg_err;
  assign bus.err_count     = err_count;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: stimulus feeds a sample-stream reference model that queues expected
// frames and errors; a negedge monitor pops and compares whenever the DUT reports one.
module tb_seg_scan_decoder;
  localparam int BLANK_MIN = 8;

  typedef struct { int value; int d1; int d2; int d3; int d4; bit changed; } frame_t;
  typedef struct { int cnt; bit blk; } err_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus();
  seg_scan_decoder #(.BLANK_MIN(BLANK_MIN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int fv_cyc[$];

  frame_t frame_q[$];
  err_t   err_q[$];

  // Reference model state, held as a list of accepted digits rather than a state machine.
  int acc[$];
  int run, errcnt_m, prev_v;
  bit blk_m, first_m;
  bit done_h[$];

  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int seg2dig(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (seg_tbl[i] == s) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] an_n, input logic [6:0] seg);
    int nlit, slot, dig;
    bit blank, valid, done, err;
    frame_t f;
    err_t e;
    nlit = 0;
    slot = 0;
    for (int i = 0; i < 4; i++)
      if (!an_n[i]) begin nlit++; slot = i + 1; end
    blank = (nlit == 0);
    dig   = seg2dig(seg);
    valid = (nlit == 1) && (dig >= 0);
    if (!blank) run = 0;
    else if (run < BLANK_MIN) run++;
    if (done_h[0]) blk_m = 1'b0;
    if (run >= BLANK_MIN) blk_m = 1'b1;
    done = 1'b0;
    err  = 1'b0;
    if (valid && slot == acc.size() + 1) begin
      acc.push_back(dig);
      if (acc.size() == 4) begin
        f.value   = acc[0] * 1000 + acc[1] * 100 + acc[2] * 10 + acc[3];
        f.d1 = acc[0]; f.d2 = acc[1]; f.d3 = acc[2]; f.d4 = acc[3];
        f.changed = first_m || (f.value != prev_v);
        prev_v    = f.value;
        first_m   = 1'b0;
        frame_q.push_back(f);
        acc.delete();
        done = 1'b1;
      end
    end else begin
      err = (acc.size() > 0) && !blank;
      acc.delete();
      if (valid && slot == 1) acc.push_back(dig);
    end
    if (err) begin
      if (errcnt_m < 255) errcnt_m++;
      e.cnt = errcnt_m;
      e.blk = blk_m;
      err_q.push_back(e);
    end
    void'(done_h.pop_front());
    done_h.push_back(done);
  endtask

  task automatic samp(input logic [3:0] an_n, input logic [6:0] seg);
    bus.a1 = an_n[0]; bus.a2 = an_n[1]; bus.a3 = an_n[2]; bus.a4 = an_n[3];
    bus.led_seg = seg;
    model_step(an_n, seg);
    @(posedge clk); #1;
  endtask

  task automatic scan(input int d, input int slot);
    logic [3:0] an;
    an = 4'b1111;
    an[slot-1] = 1'b0;
    samp(an, seg_tbl[d]);
  endtask

  task automatic blank_s();
    samp(4'b1111, 7'h7F);
  endtask

  task automatic scan_num(input int n);
    scan((n / 1000) % 10, 1);
    scan((n / 100) % 10, 2);
    scan((n / 10) % 10, 3);
    scan(n % 10, 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.a1 = 1'b1; bus.a2 = 1'b1; bus.a3 = 1'b1; bus.a4 = 1'b1;
    bus.led_seg = 7'h7F;
    @(posedge clk); #1;
    check("rst_value", bus.value, 0);
    check("rst_digits", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 0);
    check("rst_frame_valid", bus.frame_valid, 0);
    check("rst_value_changed", bus.value_changed, 0);
    check("rst_blanked", bus.blanked, 0);
    check("rst_seg_err", bus.seg_err, 0);
    check("rst_err_count", bus.err_count, 0);
    frame_q.delete();
    err_q.delete();
    acc.delete();
    done_h = '{1'b0, 1'b0};
    run = 0; errcnt_m = 0; prev_v = 0; blk_m = 1'b0; first_m = 1'b1;
    // The input register comes out of reset holding a blank sample.
    model_step(4'b1111, 7'h7F);
    rst = 1'b0;
  endtask

  frame_t mf;
  err_t   me;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("vc_without_fv", int'(bus.value_changed && !bus.frame_valid), 0);
      if (bus.frame_valid) begin
        fv_cyc.push_back(cyc);
        if (frame_q.size() == 0) check("frame_unexpected", 1, 0);
        else begin
          mf = frame_q.pop_front();
          check("value", bus.value, mf.value);
          check("digit1", bus.digit1, mf.d1);
          check("digit2", bus.digit2, mf.d2);
          check("digit3", bus.digit3, mf.d3);
          check("digit4", bus.digit4, mf.d4);
          check("value_changed", bus.value_changed, mf.changed);
          check("blanked_at_frame", bus.blanked, 0);
        end
      end
      if (bus.seg_err) begin
        if (err_q.size() == 0) check("seg_err_unexpected", 1, 0);
        else begin
          me = err_q.pop_front();
          check("err_count", bus.err_count, me.cnt);
          check("blanked_at_err", bus.blanked, me.blk);
        end
      end
    end
  end

  int n, d, r;
  initial begin
    do_reset();

    // Continuous 0150 scan: latency, cadence and first-frame value_changed.
    fv_cyc.delete();
    scan_num(150);
    scan(0, 1);
    scan(1, 2);
    check("lat_fv_early", bus.frame_valid, 0);
    scan(5, 3);
    check("lat_fv_on_time", bus.frame_valid, 1);
    check("lat_value", bus.value, 150);
    scan(0, 4);
    scan_num(150);
    repeat (4) blank_s();
    check("fv_count_0150", fv_cyc.size(), 3);
    if (fv_cyc.size() == 3) begin
      check("fv_gap_1", fv_cyc[1] - fv_cyc[0], 4);
      check("fv_gap_2", fv_cyc[2] - fv_cyc[1], 4);
    end

    // Scan joining at a3: silent until a full frame.
    scan(5, 3);
    scan(0, 4);
    scan_num(4321);
    repeat (4) blank_s();
    check("join_mid_no_err", bus.err_count, 0);

    // Bad pattern in the a2 slot.
    scan(1, 1);
    samp(4'b1101, 7'h7F);
    scan(3, 3);
    scan(4, 4);
    scan_num(5678);
    repeat (4) blank_s();
    check("bad_pattern_errs", bus.err_count, 1);

    // a1 and a2 driven together mid-frame.
    scan(2, 1);
    samp(4'b1100, seg_tbl[3]);
    scan(6, 3);
    scan(8, 4);
    scan_num(2468);
    check("multi_drive_errs", bus.err_count, 2);

    // Blank run: threshold crossing, then a 0000 frame clears it.
    repeat (BLANK_MIN) blank_s();
    check("blanked_before_min", bus.blanked, 0);
    blank_s();
    check("blanked_at_min", bus.blanked, 1);
    scan_num(0);
    check("blanked_held_lit", bus.blanked, 1);
    repeat (3) blank_s();
    check("blanked_cleared", bus.blanked, 0);
    check("zero_value", bus.value, 0);

    // Reset while capturing the third digit, after a published frame.
    scan_num(4321);
    repeat (3) blank_s();
    scan(7, 1);
    scan(7, 2);
    scan(7, 3);
    do_reset();
    repeat (4) blank_s();
    scan_num(9999);
    repeat (4) blank_s();
    check("post_reset_value", bus.value, 9999);

    // Randomized scans with injected blanks, bad patterns, multi-drive and wrong slots.
    n = 0;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) != 0) n = $urandom_range(0, 9999);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 12)) blank_s();
      for (int k = 1; k <= 4; k++) begin
        d = (k == 1) ? (n / 1000) % 10 : (k == 2) ? (n / 100) % 10 : (k == 3) ? (n / 10) % 10 : n % 10;
        r = $urandom_range(0, 99);
        if (r < 3)       blank_s();
        else if (r < 6)  samp(4'b1111 & ~(4'b0001 << (k - 1)), 7'($urandom));
        else if (r < 8)  samp(4'($urandom), seg_tbl[d]);
        else if (r < 10) scan(d, $urandom_range(1, 4));
        else             scan(d, k);
      end
    end

    repeat (6) blank_s();
    check("frames_left", frame_q.size(), 0);
    check("errs_left", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side companion to the parking meter's multiplexed seven-segment driver. It samples the active-low anode strobes and the shared segment bus, identifies each scanned digit and decodes its segment pattern back to BCD. It then reassembles complete four-digit frames, converts each frame to a binary value, and reports blanking (flash-off) intervals. It sits on the display pins and serves self-check logic and the verification bench as a readback of what the meter is actually showing.

## Interface
- BLANK_MIN, 8: number of consecutive all-anodes-off samples that sets `blanked`; range 1..255.
- clk  in  1  system clock; the meter's scan clock.
- rst  in  1  synchronous, active-high reset.
- led_seg  in  7  segment bus, active-low, bit6=a … bit0=g.
- a1, a2, a3, a4  in  1 each  digit anodes, active-low; a1 = thousands digit, a4 = units digit.
- value  out  14  binary value of the last complete frame, 0..9999.
- digit1, digit2, digit3, digit4  out  4 each  BCD digits of the last complete frame.
- frame_valid  out  1  one-cycle pulse; `value` and the digits were updated this cycle.
- value_changed  out  1  one-cycle pulse coincident with `frame_valid` when `value` differs from the previous frame.
- blanked  out  1  level; display has been dark for at least BLANK_MIN samples.
- seg_err  out  1  one-cycle pulse; a protocol or pattern error was detected.
- err_count  out  8  saturating count of `seg_err` pulses.

## Operation
- Input stage: `led_seg` and a1..a4 are registered every clk. All decoding uses the registered copies.
- Slot classification of each sample:
  - Exactly one anode low: slot k (1..4).
  - All four anodes high: blank.
  - Two or more anodes low: multi-drive error.
- Segment decode:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Any other pattern in a lit slot is a pattern error.
  - Segments are ignored in blank samples, so blank takes precedence over a bad pattern.
- Capture FSM, states HUNT, CAP2, CAP3, CAP4:
  - HUNT: a valid slot-1 sample stores d1 and moves to CAP2. Any other sample stays in HUNT with no error; errors are raised only mid-frame.
  - CAPk: the next sample must be valid slot k. On success, store dk and advance.
  - CAP4 success: hand d1..d4 to the conversion pipeline and move to HUNT in the same edge, so the immediately following slot-1 sample is accepted.
  - Mid-frame blank: abort to HUNT with no `seg_err`.
  - Mid-frame wrong slot, multi-drive, or pattern error: abort to HUNT and pulse `seg_err`.
  - A slot-1 sample that aborts a frame is itself accepted as a new d1; the FSM moves to CAP2 in that case.
- Conversion pipeline, two stages:
  - Stage A registers p_hi = d1·1000 + d2·100 and p_lo = d3·10 + d4 (14-bit each).
  - Stage B registers `value` = p_hi + p_lo and the digit outputs, and pulses `frame_valid`.
  - The pipeline accepts one frame per cycle and needs no stall logic.
- value_changed:
  - Asserts on the first `frame_valid` after reset unconditionally.
  - Thereafter asserts when the new `value` differs from the held `value`.
- Blank tracking:
  - A run counter increments on each blank sample, saturating at BLANK_MIN, and clears on any non-blank sample.
  - `blanked` sets when the counter reaches BLANK_MIN.
  - `blanked` clears on the next `frame_valid` only. Lit samples that do not complete a frame leave it set.
- err_count increments on each `seg_err` and holds at 255.

## Timing
- Reset: all outputs 0, FSM in HUNT, pipeline valids 0, run counter 0, first-frame flag set.
- Reset mid-frame or mid-pipeline: captured digits and in-flight frames are discarded; nothing is published.
- Latency: `frame_valid` asserts in the cycle after the 3rd rising edge following the edge that registers the slot-4 sample (input reg → FSM capture → stage A → stage B).
- Back-to-back scans in order a1,a2,a3,a4,a1,… produce one `frame_valid` every 4 cycles.
- `seg_err` pulses in the cycle after the FSM captures the offending sample, i.e. 2 edges after the pins are sampled.
- `blanked` rises in the cycle after the BLANK_MIN-th consecutive blank sample is counted.

## Test plan
- Continuous scan of 0150 → first `frame_valid` after the first full a1..a4; digits 0,1,5,0; `value`=150; `value_changed` only on the first frame; then `frame_valid` every 4 cycles.
- Scan begins at a3 slot → no `frame_valid` and no `seg_err` until the first complete a1..a4 frame; that frame is published correctly.
- Pattern 1111111 in the a2 slot → one `seg_err`, `err_count`=1, frame dropped; the next frame is published.
- a1 and a2 low together mid-frame → `seg_err`, abort; recovery on the following frame.
- 8 blank samples → `blanked`=1; then a 0000 scan → `frame_valid`, `value`=0, `value_changed`=1, `blanked`=0.
- rst during CAP3 → all outputs 0 the next cycle, no publish; the next full frame of 9999 gives `value`=9999 with `value_changed`=1.
